// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The frame is: SYNC, count hi, count lo, big-endian words, XOR checksum.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;
    localparam int         DEPTH_DEFAULT = 256;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Word counter must hold DEPTH itself, not just DEPTH-1.
    localparam int CNT_W = cnt_width(DEPTH_DEFAULT);

    function automatic logic state_busy(input state_t s);
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a framed byte image into instruction memory and keeps the core in
// reset until a frame with a matching XOR checksum has been fully written.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         DEPTH = DEPTH_DEFAULT,
    parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [15:0] imem_waddr,
    output logic [15:0] imem_wdata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rx_ready;
    logic            r_we;
    logic [15:0]     r_waddr;
    logic [15:0]     r_wdata;
    logic            r_core_reset;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_len_hi;
    logic [7:0]      r_data_hi;
    logic [7:0]      r_csum;
    logic [15:0]     r_addr;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_is_sync;
    logic [15:0]     w_len;
    logic            w_len_bad;
    logic            w_csum_ok;

    assign w_accept  = rx_valid && r_rx_ready;
    assign w_is_sync = (rx_data == SYNC);
    assign w_len     = {r_len_hi, rx_data};
    assign w_len_bad = (w_len > 16'(DEPTH));
    assign w_csum_ok = (rx_data == r_csum);

    // Next-state decode; only an accepted byte can move the FSM.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (w_is_sync) begin
                        w_state_nxt = ST_LEN_HI;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_LEN_HI: w_state_nxt = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (w_len_bad) begin
                        w_state_nxt = ST_ERROR;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_state_nxt = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: w_state_nxt = ST_DATA_LO;
                ST_DATA_LO: begin
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_state_nxt = ST_DATA_HI;
                    end
                end
                ST_CHECK: begin
                    if (w_csum_ok) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_rx_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= 16'd0;
            r_wdata      <= 16'd0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_len_hi     <= 8'd0;
            r_data_hi    <= 8'd0;
            r_csum       <= 8'd0;
            r_addr       <= 16'd0;
            r_cnt        <= {CW{1'b0}};
        end else begin
            r_rx_ready <= 1'b1;
            r_we       <= 1'b0;
            r_state    <= w_state_nxt;
            r_busy     <= state_busy(w_state_nxt);
            if (w_accept) begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (w_is_sync) begin
                            r_core_reset <= 1'b1;
                            r_done       <= 1'b0;
                            r_err        <= 1'b0;
                            r_csum       <= 8'd0;
                            r_addr       <= 16'd0;
                        end
                    end
                    ST_LEN_HI: r_len_hi <= rx_data;
                    ST_LEN_LO: begin
                        r_cnt <= w_len[CW-1:0];
                        if (w_len_bad) begin
                            r_err <= 1'b1;
                        end
                    end
                    ST_DATA_HI: begin
                        r_data_hi <= rx_data;
                        r_csum    <= r_csum ^ rx_data;
                    end
                    ST_DATA_LO: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= {r_data_hi, rx_data};
                        r_addr  <= r_addr + 16'd2;
                        r_csum  <= r_csum ^ rx_data;
                        r_cnt   <= r_cnt - CNT_ONE;
                    end
                    ST_CHECK: begin
                        if (w_csum_ok) begin
                            r_done       <= 1'b1;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_err        <= 1'b1;
                        end
                    end
                    default: r_err <= 1'b1;
                endcase
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
